weight_dot_sequencer: RTL
=========================

WEIGHT_DOT_SEQUENCER -- requirements
Module: weight_dot_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: Clock  in  1  rising-edge clock for all state.
REQ-003 Port: Reset  in  1  asynchronous, active-high reset.
REQ-004 Port: Start  in  1  request one evaluation; sampled only in IDLE.
REQ-005 Port: X  in  10  binary feature vector; bit i gates weight i of each neuron.
REQ-006 Port: Q  in  10  weight read data from WeightRAM; two's-complement signed.
REQ-007 Port: Address  out  5  WeightRAM word address.
REQ-008 Port: WE  out  1  WeightRAM write enable; constant 0.
REQ-009 Port: D  out  10  WeightRAM write data; constant 0.
REQ-010 Port: RamInit  out  1  drives WeightRAM In; loads its power-on weight table.
REQ-011 Port: Busy  out  1  high from the Start-accept edge until the Done edge.
REQ-012 Port: Done  out  1  one-cycle pulse; Sum0..Sum2 are valid and updated.
REQ-013 Port: Sum0, Sum1, Sum2  out  14 each  signed dot products for neurons 0, 1 and 2.

Function
REQ-014 State set SHALL be INIT, IDLE, RUN, DRAIN; registered Moore outputs except Address.
REQ-015 INIT: RamInit=1 for exactly one cycle, then IDLE; INIT is re-entered only via Reset.
REQ-016 IDLE: if Start=1 at an edge, SHALL latch X into Xreg, clear the three accumulators, set cnt=0, Busy=1, go RUN.
REQ-017 IDLE with Start=0 SHALL hold all outputs; Start during RUN/DRAIN SHALL be ignored (no queueing).
REQ-018 RUN: Address=cnt (0..29, combinational from cnt); cnt increments each cycle; after the cycle with cnt=29 go DRAIN.
REQ-019 Address SHALL be 0 in INIT, IDLE and DRAIN.
REQ-020 Read latency SHALL be one cycle: Q sampled in cycle t+1 belongs to the Address issued in cycle t; a one-stage valid flag plus delayed (neuron 0..2, bit 0..9) indices SHALL track it.
REQ-021 Word address a SHALL map to neuron a/10, bit a%10; neuron counter advances when bit wraps 9->0.
REQ-022 Accumulate: if valid and Xreg[bit]=1, acc[neuron] += sign-extend(Q) to 14 bits; otherwise acc is unchanged.
REQ-023 Range is |sum| <= 10*512 = 5120, so 14-bit signed SHALL never overflow; no saturation logic.
REQ-024 DRAIN: accumulate the final word (address 29), then on the same edge load Sum0..Sum2 from accumulators, Done=1, Busy=0, go IDLE.
REQ-025 Latency: Start sampled at edge k -> Done high after edge k+31; Busy high for 31 cycles.
REQ-026 Sum0..Sum2 SHALL hold their previous values throughout RUN and change only on the Done edge.
REQ-027 Start high in the Done cycle SHALL be accepted (back-to-back evaluations, 32-cycle period).
REQ-028 X changes after acceptance SHALL NOT affect the result.

Reset
REQ-029 Reset=1 SHALL asynchronously force state=INIT, cnt=0, valid=0, accumulators=0, Sum0..Sum2=0, Done=0, Busy=0, RamInit=0.
REQ-030 After Reset deasserts, the first edge SHALL enter INIT (RamInit=1 for one cycle), then IDLE.
REQ-031 Reset mid-RUN SHALL abort the evaluation; no Done pulse is issued and the next run restarts from address 0.

Verification
REQ-032 Reset release -> RamInit high exactly one cycle; Busy=0, Done=0, Sums=0, Address=0.
REQ-033 Power-on weight table, X=10'h3FF, Start pulse -> Done after 31 cycles with Sum0=-5, Sum1=3410, Sum2=-320.
REQ-034 X=10'h001 -> Sum0=-342, Sum1=341, Sum2=-32; X=10'h000 -> all Sums=0.
REQ-035 Address trace during RUN = 0,1,...,29 on consecutive cycles; WE=0 and D=0 throughout.
REQ-036 Reset asserted at RUN cycle 15 -> immediate INIT, Sums=0, no Done; a following run with X=10'h3FF gives REQ-033 values.
REQ-037 Start held high continuously -> Done pulses every 32 cycles; Start pulses during Busy are ignored; X toggled mid-run does not change the result.

Source files
------------

// File: rtl/weight_dot_sequencer.sv
// Three-neuron binary-input dot product engine.
// Streams 30 weight words from WeightRAM and accumulates the gated sums.
module weight_dot_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [9:0]  X,
  input  logic [9:0]  Q,
  output logic [4:0]  Address,
  output logic        WE,
  output logic [9:0]  D,
  output logic        RamInit,
  output logic        Busy,
  output logic        Done,
  output logic [13:0] Sum0,
  output logic [13:0] Sum1,
  output logic [13:0] Sum2
);

  typedef enum logic [1:0] {INIT, IDLE, RUN, DRAIN} state_t;

  state_t state, state_n;

  logic [4:0] cnt, cnt_n;
  logic [1:0] nrn, nrn_n;
  logic [3:0] bpos, bpos_n;
  logic       vld, vld_n;
  logic [1:0] vnrn, vnrn_n;
  logic [3:0] vbit, vbit_n;
  logic [9:0] xreg, xreg_n;
  logic       busy, busy_n;
  logic       done, done_n;
  logic       ram_init, ram_init_n;

  logic signed [13:0] acc [3];
  logic signed [13:0] acc_n [3];
  logic signed [13:0] acc_add [3];
  logic signed [13:0] sum [3];
  logic signed [13:0] sum_n [3];
  logic signed [13:0] q_ext;
  logic               hit;

  // Q belongs to the address issued one cycle earlier
  always_comb begin
    q_ext = {{4{Q[9]}}, Q};
    hit   = vld && xreg[vbit];
    for (int i = 0; i < 3; i++) begin
      acc_add[i] = (hit && vnrn == 2'(i)) ? acc[i] + q_ext : acc[i];
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    nrn_n      = nrn;
    bpos_n     = bpos;
    vld_n      = 1'b0;
    vnrn_n     = nrn;
    vbit_n     = bpos;
    xreg_n     = xreg;
    busy_n     = busy;
    done_n     = 1'b0;
    ram_init_n = 1'b0;
    acc_n      = acc_add;
    sum_n      = sum;
    unique case (state)
      INIT: begin
        ram_init_n = 1'b1;
        state_n    = IDLE;
      end
      IDLE: begin
        if (Start) begin
          xreg_n  = X;
          acc_n   = '{default: '0};
          cnt_n   = '0;
          nrn_n   = '0;
          bpos_n  = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        vld_n = 1'b1;
        cnt_n = cnt + 5'd1;
        if (bpos == 4'd9) begin
          bpos_n = '0;
          nrn_n  = nrn + 2'd1;
        end else begin
          bpos_n = bpos + 4'd1;
        end
        if (cnt == 5'd29) state_n = DRAIN;
      end
      DRAIN: begin
        sum_n   = acc_add;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= INIT;
      cnt      <= '0;
      nrn      <= '0;
      bpos     <= '0;
      vld      <= 1'b0;
      vnrn     <= '0;
      vbit     <= '0;
      xreg     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_init <= 1'b0;
      acc      <= '{default: '0};
      sum      <= '{default: '0};
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      nrn      <= nrn_n;
      bpos     <= bpos_n;
      vld      <= vld_n;
      vnrn     <= vnrn_n;
      vbit     <= vbit_n;
      xreg     <= xreg_n;
      busy     <= busy_n;
      done     <= done_n;
      ram_init <= ram_init_n;
      acc      <= acc_n;
      sum      <= sum_n;
    end
  end

  assign Address = (state == RUN) ? cnt : 5'd0;
  assign WE      = 1'b0;
  assign D       = 10'd0;
  assign RamInit = ram_init;
  assign Busy    = busy;
  assign Done    = done;
  assign Sum0    = sum[0];
  assign Sum1    = sum[1];
  assign Sum2    = sum[2];

endmodule
